// File: rtl/gp02_win_accum.sv
// Windowed selectable-input accumulator with valid/ready result handshake.
// Define GP02_ACC_SAT_EN to saturate the accumulator on carry instead of wrapping.
module gp02_win_accum #(
    parameter int DATA_W  = 3,
    parameter int ACC_W   = 6,
    parameter int WIN_LEN = 8
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_data1,
    input  logic [DATA_W-1:0] i_data2,
    input  logic [1:0]        i_sel,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_clear,
    output logic [ACC_W-1:0]  o_data,
    output logic              o_overflow,
    output logic              o_valid,
    input  logic              i_ready
);

    localparam int CNT_W = $clog2(WIN_LEN + 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic [DATA_W:0]    sel_val;
    logic [ACC_W:0]     sum;
    logic               carry;
    logic               accept;
    logic               last;

    always_comb begin
        sel_val = '0;
        unique case (i_sel)
            2'b00:   sel_val = {1'b0, i_data2};
            2'b01:   sel_val = {1'b0, i_data1} + {1'b0, i_data2};
            2'b10:   sel_val = {1'b0, i_data1};
            default: sel_val = '0;
        endcase
    end

    assign sum    = {1'b0, acc_q} + (ACC_W + 1)'(sel_val);
    assign carry  = sum[ACC_W];
    assign accept = i_valid & o_ready;
    assign last   = (cnt_q == CNT_W'(WIN_LEN - 1));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (i_clear) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (accept) begin
`ifdef GP02_ACC_SAT_EN
                        acc_d = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
                        acc_d = sum[ACC_W-1:0];
`endif
                        ovf_d = ovf_q | carry;
                        if (last) begin
                            state_d = HOLD;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    // Result consumed: next window starts from zero.
                    if (i_ready) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_ready    = (state_q == ACCUM);
    assign o_valid    = (state_q == HOLD);
    assign o_data     = acc_q;
    assign o_overflow = ovf_q;

endmodule
